// File: rtl/freq_pkg.sv
// Shared types and elaboration helpers for the period-to-frequency converter.
package freq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int unsigned DEF_CLK_FREQ = 200_000_000;

  // True when the largest (rounded) dividend still fits in freq_w bits.
  function automatic bit freq_width_ok(input longint unsigned clk_freq,
                                       input int unsigned     cnt_w,
                                       input int unsigned     freq_w);
    longint unsigned worst;
    if (freq_w >= 63 || cnt_w == 0) return 1'b0;
    worst = clk_freq + (64'd1 << (cnt_w - 1));
    return worst < (64'd1 << freq_w);
  endfunction

endpackage

// File: rtl/seq_divider_u.sv
// Unsigned restoring divider, one quotient bit per cycle; NUM_W iterations per start.
module seq_divider_u #(
  parameter int unsigned NUM_W = 28,
  parameter int unsigned DEN_W = 18
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [NUM_W-1:0] numerator,
  input  logic [DEN_W-1:0] denominator,
  output logic             busy,
  output logic             done_c,
  output logic [NUM_W-1:0] quotient,
  output logic [DEN_W-1:0] remainder
);

  localparam int unsigned CNT_W = (NUM_W > 1) ? $clog2(NUM_W) : 1;

  logic [CNT_W-1:0] cnt;
  logic [DEN_W-1:0] den_q;
  logic [DEN_W:0]   rem_next_c;
  logic             fits_c;

  // The quotient register doubles as the dividend shift register.
  assign rem_next_c = {remainder, quotient[NUM_W-1]};
  assign fits_c     = rem_next_c >= {1'b0, den_q};
  // High during the final iteration; the quotient is complete after this edge.
  assign done_c     = busy && (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      cnt       <= '0;
      den_q     <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else if (abort) begin
      busy <= 1'b0;
    end else if (start) begin
      busy      <= 1'b1;
      cnt       <= CNT_W'(NUM_W - 1);
      den_q     <= denominator;
      quotient  <= numerator;
      remainder <= '0;
    end else if (busy) begin
      quotient  <= {quotient[NUM_W-2:0], fits_c};
      remainder <= fits_c ? DEN_W'(rem_next_c - {1'b0, den_q}) : DEN_W'(rem_next_c);
      cnt       <= cnt - CNT_W'(1);
      if (cnt == '0) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/period_to_freq.sv
// Converts the detector's averaged period into Hz (CLK_FREQ / period) on each new stable period.
// Define PERIOD_TO_FREQ_ROUND_EN for round-to-nearest; default result is floor.
module period_to_freq
  import freq_pkg::*;
#(
  parameter int unsigned CLK_FREQ      = DEF_CLK_FREQ,
  parameter int unsigned COUNTER_WIDTH = 18,
  parameter int unsigned FREQ_WIDTH    = 28
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [COUNTER_WIDTH-1:0] period,
  input  logic                     stable,
  output logic [FREQ_WIDTH-1:0]    freq_out,
  output logic                     freq_valid,
  output logic                     freq_locked,
  output logic                     busy
);

  if (!freq_width_ok(64'(CLK_FREQ), COUNTER_WIDTH, FREQ_WIDTH)) begin : g_width_check
    $error("period_to_freq: FREQ_WIDTH too narrow for CLK_FREQ");
  end

  state_t                   state, state_next;
  logic [COUNTER_WIDTH-1:0] last_period;
  logic                     trig_c, start_c, abort_c;
  logic [FREQ_WIDTH-1:0]    dividend_c;
  logic                     div_busy, div_done_c;
  logic [FREQ_WIDTH-1:0]    div_quo;
  logic [COUNTER_WIDTH-1:0] div_rem;
  logic                     unused_div;

`ifdef PERIOD_TO_FREQ_ROUND_EN
  assign dividend_c = FREQ_WIDTH'(CLK_FREQ) + FREQ_WIDTH'(period >> 1);
`else
  assign dividend_c = FREQ_WIDTH'(CLK_FREQ);
`endif

  // A zero period is never a trigger, so the divider never sees a zero divisor.
  assign trig_c = stable && (period != '0) && (period != last_period);

  seq_divider_u #(
    .NUM_W(FREQ_WIDTH),
    .DEN_W(COUNTER_WIDTH)
  ) u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start_c),
    .abort      (abort_c),
    .numerator  (dividend_c),
    .denominator(period),
    .busy       (div_busy),
    .done_c     (div_done_c),
    .quotient   (div_quo),
    .remainder  (div_rem)
  );

  // Remainder and divider busy are not needed by this wrapper.
  assign unused_div = ^{div_rem, div_busy};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    start_c    = 1'b0;
    abort_c    = 1'b0;
    case (state)
      IDLE: if (trig_c) state_next = LOAD;
      LOAD: begin
        if (!stable) begin
          state_next = IDLE;
        end else begin
          state_next = DIV;
          start_c    = 1'b1;
        end
      end
      DIV: begin
        if (!stable) begin
          state_next = IDLE;
          abort_c    = 1'b1;
        end else if (div_done_c) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output and last-period registers; losing stable forgets the period so re-lock recomputes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      freq_out    <= '0;
      freq_valid  <= 1'b0;
      freq_locked <= 1'b0;
      busy        <= 1'b0;
      last_period <= '0;
    end else begin
      freq_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (!stable) begin
            freq_locked <= 1'b0;
            last_period <= '0;
          end else if (trig_c) begin
            freq_locked <= 1'b0;
          end
        end
        LOAD: begin
          if (!stable) begin
            freq_locked <= 1'b0;
            busy        <= 1'b0;
            last_period <= '0;
          end else begin
            last_period <= period;
            busy        <= 1'b1;
          end
        end
        DIV: begin
          if (!stable) begin
            freq_locked <= 1'b0;
            busy        <= 1'b0;
            last_period <= '0;
          end
        end
        DONE: begin
          freq_out    <= div_quo;
          freq_valid  <= 1'b1;
          freq_locked <= 1'b1;
          busy        <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_period_to_freq.sv
// Self-checking bench for period_to_freq: directed corner sequences plus a table of periods.
module tb_period_to_freq;

  localparam int unsigned CLK_FREQ = 200_000_000;
  localparam int unsigned CW       = 18;
  localparam int unsigned FW       = 28;
  localparam int          NVEC     = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CW-1:0] period;
  logic          stable;
  logic [FW-1:0] freq_out;
  logic          freq_valid;
  logic          freq_locked;
  logic          busy;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [CW-1:0]   period;
    longint unsigned freq;
  } vec_t;

  vec_t vecs[NVEC];

  always #5 clk = ~clk;

  period_to_freq #(
    .CLK_FREQ     (CLK_FREQ),
    .COUNTER_WIDTH(CW),
    .FREQ_WIDTH   (FW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .period     (period),
    .stable     (stable),
    .freq_out   (freq_out),
    .freq_valid (freq_valid),
    .freq_locked(freq_locked),
    .busy       (busy)
  );

  function automatic longint unsigned ref_freq(input longint unsigned p);
    longint unsigned num;
    num = CLK_FREQ;
`ifdef PERIOD_TO_FREQ_ROUND_EN
    num = num + p / 2;
`endif
    return num / p;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Ticks until freq_valid is seen; ticks = -1 if the bound expires.
  task automatic wait_pulse(input int limit, output int ticks, output int busy_n);
    ticks  = -1;
    busy_n = 0;
    for (int i = 1; i <= limit; i++) begin
      tick();
      if (busy === 1'b1) busy_n++;
      if (freq_valid === 1'b1) begin
        ticks = i;
        break;
      end
    end
  endtask

  task automatic count_pulses(input int cycles, output int pulses, output int busy_n);
    pulses = 0;
    busy_n = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (freq_valid !== 1'b0) pulses++;
      if (busy !== 1'b0) busy_n++;
    end
  endtask

  task automatic wait_busy(output int seen);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (busy === 1'b1) begin
        seen = 1;
        break;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          ticks, busy_n, pulses, seen;
    longint      exp3;
    int unsigned fixed_p[8];
    logic [CW-1:0] prev, p;

    // Reset state
    stable = 1'b0;
    period = '0;
    rst_n  = 1'b0;
    repeat (2) tick();
    check("reset freq_out", freq_out, 0);
    check("reset freq_valid", freq_valid, 0);
    check("reset freq_locked", freq_locked, 0);
    check("reset busy", busy, 0);

    // period=0 while stable is ignored
    stable = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    count_pulses(50, pulses, busy_n);
    check("zero period pulses", pulses, 0);
    check("zero period busy cycles", busy_n, 0);
    check("zero period freq_out", freq_out, 0);
    check("zero period locked", freq_locked, 0);

    // period=2000 from reset: latency, busy length, value
    rst_n  = 1'b0;
    period = CW'(2000);
    do_reset();
    wait_pulse(60, ticks, busy_n);
    // The first edge after release samples the trigger in IDLE.
    check("p2000 latency", ticks - 1, FW + 2);
    check("p2000 busy cycles", busy_n, FW + 1);
    check("p2000 freq_out", freq_out, 100000);
    check("p2000 locked", freq_locked, 1);
    tick();
    check("p2000 valid one cycle", freq_valid, 0);
    count_pulses(40, pulses, busy_n);
    check("unchanged period pulses", pulses, 0);
    check("unchanged period busy", busy_n, 0);
    check("unchanged period locked", freq_locked, 1);
    check("unchanged period freq_out", freq_out, 100000);

    // period=3: floor vs rounded
`ifdef PERIOD_TO_FREQ_ROUND_EN
    exp3 = 66666667;
`else
    exp3 = 66666666;
`endif
    period = CW'(3);
    wait_pulse(60, ticks, busy_n);
    check("p3 latency", ticks - 1, FW + 2);
    check("p3 freq_out", freq_out, exp3);

    // period drops to 0 while locked: ignored, outputs unchanged
    period = '0;
    count_pulses(40, pulses, busy_n);
    check("locked zero period pulses", pulses, 0);
    check("locked zero period freq_out", freq_out, exp3);
    check("locked zero period locked", freq_locked, 1);

    period = CW'(2000);
    wait_pulse(60, ticks, busy_n);
    check("p2000 again freq_out", freq_out, 100000);

    // stable falls mid-division: abort, hold freq_out, re-lock recomputes
    period = CW'(200000);
    wait_busy(seen);
    check("abort busy seen", seen, 1);
    repeat (10) tick();
    stable = 1'b0;
    tick();
    check("abort busy", busy, 0);
    check("abort locked", freq_locked, 0);
    count_pulses(40, pulses, busy_n);
    check("abort pulses", pulses, 0);
    check("abort freq_out held", freq_out, 100000);
    check("abort locked stays low", freq_locked, 0);
    stable = 1'b1;
    wait_pulse(60, ticks, busy_n);
    check("relock latency", ticks - 1, FW + 2);
    check("relock freq_out", freq_out, 1000);
    check("relock locked", freq_locked, 1);

    // period changes mid-division: first result completes, then recompute
    period = CW'(2000);
    wait_busy(seen);
    check("midchange busy seen", seen, 1);
    repeat (5) tick();
    period = CW'(4000);
    wait_pulse(60, ticks, busy_n);
    check("midchange first pulse seen", ticks > 0, 1);
    check("midchange first freq_out", freq_out, 100000);
    wait_pulse(60, ticks, busy_n);
    check("midchange second pulse seen", ticks > 0, 1);
    check("midchange second freq_out", freq_out, 50000);
    check("midchange locked", freq_locked, 1);

    // Table of periods: corners plus random values, checked against the model
    fixed_p = '{1, 2, 7, 1000, 65535, 65536, 262143, 131072};
    prev    = CW'(4000);
    for (int i = 0; i < NVEC; i++) begin
      if (i < 8) begin
        p = CW'(fixed_p[i]);
      end else begin
        p = CW'($urandom_range(1, (1 << CW) - 1));
        while (p == prev || p == CW'(3000)) p = CW'($urandom_range(1, (1 << CW) - 1));
      end
      vecs[i].period = p;
      vecs[i].freq   = ref_freq(longint'(p));
      prev           = p;
    end
    for (int i = 0; i < NVEC; i++) begin
      period = vecs[i].period;
      wait_pulse(60, ticks, busy_n);
      check($sformatf("vec%0d p=%0d latency", i, vecs[i].period), ticks - 1, FW + 2);
      check($sformatf("vec%0d p=%0d freq_out", i, vecs[i].period), freq_out, vecs[i].freq);
      check($sformatf("vec%0d p=%0d locked", i, vecs[i].period), freq_locked, 1);
    end

    // Asynchronous reset in the middle of a division
    period = CW'(3000);
    wait_busy(seen);
    check("mid reset busy seen", seen, 1);
    repeat (8) tick();
    rst_n = 1'b0;
    #1;
    check("mid reset freq_out", freq_out, 0);
    check("mid reset freq_valid", freq_valid, 0);
    check("mid reset locked", freq_locked, 0);
    check("mid reset busy", busy, 0);
    repeat (2) tick();
    @(negedge clk);
    rst_n = 1'b1;
    wait_pulse(60, ticks, busy_n);
    check("post reset latency", ticks - 1, FW + 2);
    check("post reset freq_out", freq_out, ref_freq(3000));
    check("post reset locked", freq_locked, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
